// File: rtl/refclk_second_strobe.sv
// refclk_second_strobe
// Timebase generator. It brings the asynchronous 32.768 kHz reference into
// the i_sysclk domain, divides the reference edges into a one-cycle 1 Hz
// strobe and a faster time-set strobe, and watches the reference for loss.
module refclk_second_strobe #(
  parameter int unsigned REFCLK_DIV = 32768,
  parameter int unsigned FAST_DIV   = 128,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic i_sysclk,
  input  logic i_reset,
  input  logic i_refclk,
  input  logic i_en,
  input  logic i_fast_set,
  output logic o_1hz_stb,
  output logic o_fast_stb,
  output logic o_ref_lost
);

  // Last prescaler value before the wrap back to zero.
  localparam logic [15:0] P_LAST    = 16'(REFCLK_DIV - 1);
  // FAST_DIV is a power of two, so the fast strobe is due whenever the low
  // bits of the prescaler are all ones. A mask also covers FAST_DIV == 1.
  localparam logic [15:0] FAST_MASK = 16'(FAST_DIV - 1);
  localparam logic [15:0] T_LIMIT   = 16'(TIMEOUT);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic [15:0] r_pCount;
  logic [15:0] r_tCount;

  logic        w_refEdge;
  logic        w_countEdge;
  logic        w_pWrap;
  logic        w_fastDue;
  logic [15:0] w_pCountNext;
  logic [15:0] w_tCountNext;

  // Rising edge of the reference, taken only from the metastability-safe stages.
  assign w_refEdge   = r_sync2 & ~r_sync3;
  assign w_countEdge = w_refEdge & i_en;
  assign w_pWrap     = (r_pCount == P_LAST);
  assign w_fastDue   = ((r_pCount & FAST_MASK) == FAST_MASK);

  // Next prescaler and watchdog values.
  always_comb begin
    w_pCountNext = r_pCount;
    if (w_countEdge) begin
      if (w_pWrap) begin
        w_pCountNext = 16'd0;
      end else begin
        w_pCountNext = r_pCount + 16'd1;
      end
    end

    w_tCountNext = r_tCount;
    if (w_refEdge) begin
      w_tCountNext = 16'd0;
    end else if (r_tCount != T_LIMIT) begin
      w_tCountNext = r_tCount + 16'd1;
    end
  end

  // Three-stage synchronizer for the asynchronous reference.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_refclk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Prescaler and registered strobes; both strobes coincide at the wrap.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_pCount   <= 16'd0;
      o_1hz_stb  <= 1'b0;
      o_fast_stb <= 1'b0;
    end else begin
      r_pCount   <= w_pCountNext;
      o_1hz_stb  <= w_countEdge & w_pWrap;
      o_fast_stb <= w_countEdge & i_fast_set & w_fastDue;
    end
  end

  // Watchdog: saturating count of cycles since the last reference edge.
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      r_tCount   <= 16'd0;
      o_ref_lost <= 1'b0;
    end else begin
      r_tCount   <= w_tCountNext;
      o_ref_lost <= (w_tCountNext == T_LIMIT);
    end
  end

endmodule
